cdb_arbiter: RTL and testbench

Collects result broadcasts from the functional-unit reservation stations and drives the two common data bus lanes (CDBiscast/CDBrobNum/CDBdata and CDBiscast2/CDBrobNum2/CDBdata2) that every reservation station and the ROB snoop. Each source gets a small FIFO, so a result is never lost when more than two units finish in the same cycle. Per cycle, round-robin arbitration grants up to two results, one per lane.

---
 rtl/cdb_arbiter_if.sv | 30 +++
 rtl/cdb_arbiter.sv | 126 ++++++++++++
 tb/tb_cdb_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Result-source handshake and dual common-data-bus lanes shared by the reservation stations and the ROB.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ROB_W   = 6
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*ROB_W-1:0]  src_rob;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      flush;
  logic                      CDBiscast;
  logic [ROB_W-1:0]          CDBrobNum;
  logic [DATA_W-1:0]         CDBdata;
  logic                      CDBiscast2;
  logic [ROB_W-1:0]          CDBrobNum2;
  logic [DATA_W-1:0]         CDBdata2;

  // Source side: functional units presenting results.
  modport master (
    output src_valid, src_rob, src_data, flush,
    input  src_ready, CDBiscast, CDBrobNum, CDBdata, CDBiscast2, CDBrobNum2, CDBdata2
  );

  // Arbiter side: queues results and drives both lanes.
  modport slave (
    input  src_valid, src_rob, src_data, flush,
    output src_ready, CDBiscast, CDBrobNum, CDBdata, CDBiscast2, CDBrobNum2, CDBdata2
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Per-source result FIFOs with round-robin grant of up to two results per cycle onto the CDB lanes.
module cdb_arbiter #(
  parameter int unsigned     NUM_SRC     = 4,
  parameter int unsigned     DEPTH       = 2,
  parameter int unsigned     DATA_W      = 32,
  parameter int unsigned     ROB_W       = 6,
  parameter logic [ROB_W-1:0] INVALID_TAG = ROB_W'(16)
) (
  input  logic         clock,
  input  logic         rst_n,
  cdb_arbiter_if.slave bus
);

  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ROB_W-1:0]  tag_mem  [NUM_SRC][DEPTH];
  logic [DATA_W-1:0] data_mem [NUM_SRC][DEPTH];
  logic [PTR_W-1:0]  rd_ptr   [NUM_SRC];
  logic [PTR_W-1:0]  wr_ptr   [NUM_SRC];
  logic [CNT_W-1:0]  count    [NUM_SRC];
  logic [SRC_W-1:0]  rr_ptr;

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic               g0_valid;
  logic               g1_valid;
  logic [SRC_W-1:0]   g0_idx;
  logic [SRC_W-1:0]   g1_idx;
  logic [SRC_W-1:0]   scan_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : PTR_W'(p + PTR_W'(1));
  endfunction

  function automatic logic [SRC_W-1:0] src_inc(input logic [SRC_W-1:0] s);
    return (32'(s) == NUM_SRC - 1) ? '0 : SRC_W'(s + SRC_W'(1));
  endfunction

  // Ready depends on registered occupancy only; a same-cycle pop never frees space.
  always_comb begin
    bus.src_ready = '0;
    push          = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      bus.src_ready[k] = (count[k] != CNT_W'(DEPTH)) && rst_n && !bus.flush;
      push[k]          = bus.src_valid[k] && bus.src_ready[k];
    end
  end

  // Scan from rr_ptr: first non-empty source gets lane 0, next distinct one gets lane 1.
  always_comb begin
    g0_valid = 1'b0;
    g1_valid = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    scan_idx = rr_ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (count[scan_idx] != '0) begin
        if (!g0_valid) begin
          g0_valid = 1'b1;
          g0_idx   = scan_idx;
        end else if (!g1_valid) begin
          g1_valid = 1'b1;
          g1_idx   = scan_idx;
        end
      end
      scan_idx = src_inc(scan_idx);
    end
  end

  always_comb begin
    pop = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pop[k] = (g0_valid && (g0_idx == SRC_W'(k))) || (g1_valid && (g1_idx == SRC_W'(k)));
    end
  end

  // FIFO bookkeeping; flush and reset both empty every queue.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!rst_n || bus.flush) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        count[k]  <= '0;
      end else begin
        if (push[k]) wr_ptr[k] <= ptr_inc(wr_ptr[k]);
        if (pop[k])  rd_ptr[k] <= ptr_inc(rd_ptr[k]);
        if (push[k] && !pop[k])      count[k] <= count[k] + CNT_W'(1);
        else if (!push[k] && pop[k]) count[k] <= count[k] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_SRC; k++) begin
      if (push[k]) begin
        tag_mem[k][wr_ptr[k]]  <= bus.src_rob[k*ROB_W +: ROB_W];
        data_mem[k][wr_ptr[k]] <= bus.src_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Registered lane outputs and round-robin pointer.
  always_ff @(posedge clock) begin
    if (!rst_n || bus.flush) begin
      bus.CDBiscast  <= 1'b0;
      bus.CDBrobNum  <= INVALID_TAG;
      bus.CDBdata    <= '0;
      bus.CDBiscast2 <= 1'b0;
      bus.CDBrobNum2 <= INVALID_TAG;
      bus.CDBdata2   <= '0;
      rr_ptr         <= '0;
    end else begin
      bus.CDBiscast  <= g0_valid;
      bus.CDBrobNum  <= g0_valid ? tag_mem[g0_idx][rd_ptr[g0_idx]]  : INVALID_TAG;
      bus.CDBdata    <= g0_valid ? data_mem[g0_idx][rd_ptr[g0_idx]] : '0;
      bus.CDBiscast2 <= g1_valid;
      bus.CDBrobNum2 <= g1_valid ? tag_mem[g1_idx][rd_ptr[g1_idx]]  : INVALID_TAG;
      bus.CDBdata2   <= g1_valid ? data_mem[g1_idx][rd_ptr[g1_idx]] : '0;
      if (g1_valid)      rr_ptr <= src_inc(g1_idx);
      else if (g0_valid) rr_ptr <= src_inc(g0_idx);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: queue-based reference model feeds expected broadcasts to a negedge monitor.
module tb_cdb_arbiter;
  localparam int unsigned     NUM_SRC     = 4;
  localparam int unsigned     DEPTH       = 2;
  localparam int unsigned     DATA_W      = 32;
  localparam int unsigned     ROB_W       = 6;
  localparam logic [ROB_W-1:0] INVALID_TAG = 6'b010000;

  typedef struct { logic [ROB_W-1:0] tag; logic [DATA_W-1:0] data; } res_t;
  typedef struct { int cyc; int lane; logic [ROB_W-1:0] tag; logic [DATA_W-1:0] data; } exp_t;

  logic clock = 1'b0;
  logic rst_n;
  initial forever #5 clock = ~clock;

  cdb_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ROB_W(ROB_W)) bus();

  cdb_arbiter #(
    .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .INVALID_TAG(INVALID_TAG)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  res_t mq[NUM_SRC][$];
  exp_t exp_q[$];
  int   rr = 0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   fair_armed = 0;
  int   fair_push_cyc = 0;
  bit   flush_watch = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: each source is a queue; grants are the first two non-empty queues from rr.
  int   m_sz[NUM_SRC];
  int   m_g[$];
  res_t m_r;
  initial forever begin
    @(posedge clock);
    cyc++;
    if (!rst_n || bus.flush) begin
      for (int k = 0; k < NUM_SRC; k++) mq[k].delete();
      rr = 0;
    end else begin
      m_g.delete();
      for (int k = 0; k < NUM_SRC; k++) m_sz[k] = mq[k].size();
      for (int i = 0; i < NUM_SRC; i++) begin
        if (m_sz[(rr + i) % NUM_SRC] > 0 && m_g.size() < 2) m_g.push_back((rr + i) % NUM_SRC);
      end
      for (int j = 0; j < m_g.size(); j++) begin
        m_r = mq[m_g[j]].pop_front();
        exp_q.push_back('{cyc, j, m_r.tag, m_r.data});
      end
      if (m_g.size() > 0) rr = (m_g[m_g.size()-1] + 1) % NUM_SRC;
      for (int k = 0; k < NUM_SRC; k++) begin
        if (bus.src_valid[k]) begin
          chk("protocol_push_when_full", 64'(m_sz[k] < int'(DEPTH)), 64'd1);
          if (m_sz[k] < int'(DEPTH))
            mq[k].push_back('{bus.src_rob[k*ROB_W +: ROB_W], bus.src_data[k*DATA_W +: DATA_W]});
        end
      end
    end
  end

  // Monitor: compare ready and both lanes against what the model scheduled for this cycle.
  logic [NUM_SRC-1:0] mon_er;
  bit   mon_h0, mon_h1;
  exp_t mon_e0, mon_e1, mon_e;
  initial forever begin
    @(negedge clock);
    if (cyc > 0) begin
      for (int k = 0; k < NUM_SRC; k++)
        mon_er[k] = rst_n && !bus.flush && (mq[k].size() < int'(DEPTH));
      chk("src_ready", 64'(bus.src_ready), 64'(mon_er));
      mon_h0 = 0;
      mon_h1 = 0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        mon_e = exp_q.pop_front();
        if (mon_e.lane == 0) begin mon_h0 = 1; mon_e0 = mon_e; end
        else                 begin mon_h1 = 1; mon_e1 = mon_e; end
      end
      chk("lane0 {iscast,tag,data}", 64'({bus.CDBiscast, bus.CDBrobNum, bus.CDBdata}),
          mon_h0 ? 64'({1'b1, mon_e0.tag, mon_e0.data}) : 64'({1'b0, INVALID_TAG, 32'h0}));
      chk("lane1 {iscast,tag,data}", 64'({bus.CDBiscast2, bus.CDBrobNum2, bus.CDBdata2}),
          mon_h1 ? 64'({1'b1, mon_e1.tag, mon_e1.data}) : 64'({1'b0, INVALID_TAG, 32'h0}));
      if (flush_watch) begin
        chk("flushed_tag_lane0", 64'(bus.CDBiscast && (bus.CDBrobNum inside {[6'd40:6'd43]})), 64'd0);
        chk("flushed_tag_lane1", 64'(bus.CDBiscast2 && (bus.CDBrobNum2 inside {[6'd40:6'd43]})), 64'd0);
      end
      if (fair_armed) begin
        if ((bus.CDBiscast && bus.CDBrobNum == 6'h3F) || (bus.CDBiscast2 && bus.CDBrobNum2 == 6'h3F)) begin
          chk("fairness_wait_le_2", 64'(cyc - fair_push_cyc <= 2), 64'd1);
          fair_armed = 0;
        end else if (cyc - fair_push_cyc > 2) begin
          chk("fairness_timeout", 64'(cyc - fair_push_cyc), 64'd2);
          fair_armed = 0;
        end
      end
    end
  end

  task automatic step(input logic [NUM_SRC-1:0] v, input logic [NUM_SRC*ROB_W-1:0] rob,
                      input logic [NUM_SRC*DATA_W-1:0] dat, input logic fl);
    bus.src_valid = v;
    bus.src_rob   = rob;
    bus.src_data  = dat;
    bus.flush     = fl;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, '0, 1'b0);
  endtask

  logic [NUM_SRC-1:0]        v;
  logic [NUM_SRC*ROB_W-1:0]  rv;
  logic [NUM_SRC*DATA_W-1:0] dv;

  initial begin
    rst_n         = 1'b0;
    bus.src_valid = '0;
    bus.src_rob   = '0;
    bus.src_data  = '0;
    bus.flush     = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    rst_n = 1'b1;

    // Single result from source 2.
    rv = '0; dv = '0;
    rv[2*ROB_W +: ROB_W] = 6'd5;
    dv[2*DATA_W +: DATA_W] = 32'h0000_00AA;
    step(4'b0100, rv, dv, 1'b0);
    idle(3);

    // Flush to return rr to 0, then a four-way collision.
    step('0, '0, '0, 1'b1);
    rv = {6'd4, 6'd3, 6'd2, 6'd1};
    dv = {32'h104, 32'h103, 32'h102, 32'h101};
    step(4'b1111, rv, dv, 1'b0);
    idle(3);

    // Lone source streaming across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      rv = '0; dv = '0;
      rv[0 +: ROB_W] = ROB_W'(10 + i);
      dv[0 +: DATA_W] = DATA_W'(i * 7 + 1);
      step(4'b0001, rv, dv, 1'b0);
    end
    idle(3);

    // Fairness: sources 0 and 1 kept busy while source 3 injects one result.
    for (int c = 0; c < 10; c++) begin
      v = '0; rv = '0; dv = '0;
      for (int k = 0; k < 2; k++) begin
        if (mq[k].size() < int'(DEPTH)) begin
          v[k] = 1'b1;
          rv[k*ROB_W +: ROB_W] = ROB_W'(20 + c);
          dv[k*DATA_W +: DATA_W] = DATA_W'(c * 16 + k);
        end
      end
      if (c == 3) begin
        v[3] = 1'b1;
        rv[3*ROB_W +: ROB_W] = 6'h3F;
        dv[3*DATA_W +: DATA_W] = 32'hFA1F_0003;
        fair_armed = 1;
        fair_push_cyc = cyc + 1;
      end
      step(v, rv, dv, 1'b0);
    end
    idle(4);

    // Flush with three queued results plus a same-edge push.
    rv = '0; dv = '0;
    rv[0 +: ROB_W] = 6'd40; rv[ROB_W +: ROB_W] = 6'd41; rv[2*ROB_W +: ROB_W] = 6'd42;
    dv = {32'h0, 32'h42, 32'h41, 32'h40};
    step(4'b0111, rv, dv, 1'b0);
    rv = '0; rv[3*ROB_W +: ROB_W] = 6'd43;
    dv = '0; dv[3*DATA_W +: DATA_W] = 32'h43;
    flush_watch = 1;
    step(4'b1000, rv, dv, 1'b1);
    idle(6);
    flush_watch = 0;

    // Reset while results are in flight and queued.
    rv = '0; dv = '0;
    rv[0 +: ROB_W] = 6'd50; rv[ROB_W +: ROB_W] = 6'd51;
    dv[0 +: DATA_W] = 32'h50; dv[DATA_W +: DATA_W] = 32'h51;
    step(4'b0011, rv, dv, 1'b0);
    rv = '0; dv = '0;
    rv[0 +: ROB_W] = 6'd52; dv[0 +: DATA_W] = 32'h52;
    step(4'b0001, rv, dv, 1'b0);
    rv = '0; dv = '0;
    rv[ROB_W +: ROB_W] = 6'd53; dv[DATA_W +: DATA_W] = 32'h53;
    step(4'b0010, rv, dv, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(4);

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      v = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
        rv[k*ROB_W +: ROB_W]   = ROB_W'($urandom_range(0, 62));
        dv[k*DATA_W +: DATA_W] = $urandom;
        if ($urandom_range(0, 99) < 70 && mq[k].size() < int'(DEPTH)) v[k] = 1'b1;
      end
      step(v, rv, dv, ($urandom_range(0, 59) == 0));
    end
    rst_n = 1'b1;
    idle(6);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    for (int k = 0; k < NUM_SRC; k++) chk("model_queue_empty", 64'(mq[k].size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
